// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU data port and screen-refresh reads share one
// synchronous memory through an IDLE -> ACCESS -> RESP sequence.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter bit          CPU_PRIO  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        scr_req,
  input  logic [31:0] scr_addr,
  output logic        scr_ack,
  output logic [31:0] scr_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_SCR} owner_t;

  state_t      state;
  owner_t      owner;
  owner_t      last_owner;
  logic        in_range;

  logic        pick_cpu;
  logic [31:0] sel_addr;
  logic        sel_wen;
  logic        sel_in_range;

  // Round-robin hands contention to whoever was not served last.
  always_comb begin
    pick_cpu     = cpu_req && (!scr_req || CPU_PRIO || (last_owner == OWN_SCR));
    sel_addr     = pick_cpu ? cpu_addr : scr_addr;
    sel_wen      = pick_cpu && cpu_wen;
    sel_in_range = (sel_addr < MEM_BYTES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_SCR;
      in_range   <= 1'b0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      scr_ack    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      scr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || scr_req) begin
            owner     <= pick_cpu ? OWN_CPU : OWN_SCR;
            mem_addr  <= sel_addr;
            mem_wdata <= pick_cpu ? cpu_wdata : 32'h0;
            in_range  <= sel_in_range;
            mem_ren   <= !sel_wen && sel_in_range;
            mem_wen   <= sel_wen && sel_in_range;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
          cpu_ack <= (owner == OWN_CPU);
          scr_ack <= (owner == OWN_SCR);
          state   <= RESP;
        end
        RESP: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory data arrives in the ack cycle, so it is steered combinationally.
  assign cpu_rdata = (cpu_ack && in_range) ? mem_rdata : 32'h0;
  assign scr_rdata = (scr_ack && in_range) ? mem_rdata : 32'h0;
  assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model; a second instance with CPU priority shares the stimulus.
module tb_mem_arbiter;

  localparam int unsigned MB = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wen = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        scr_req = 1'b0;
  logic [31:0] scr_addr = '0;
  logic        cpu_ack, cpu_stall, scr_ack;
  logic [31:0] cpu_rdata, scr_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        p_cpu_ack, p_cpu_stall, p_scr_ack, p_mem_ren, p_mem_wen;
  logic [31:0] p_cpu_rdata, p_scr_rdata, p_mem_addr, p_mem_wdata;
  logic [31:0] p_mem_rdata = '0;

  int passed = 0, total = 0, fails = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  mem_arbiter #(.MEM_BYTES(MB), .CPU_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_ack(scr_ack), .scr_rdata(scr_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_BYTES(MB), .CPU_PRIO(1'b1)) u_prio (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(p_cpu_ack), .cpu_stall(p_cpu_stall), .cpu_rdata(p_cpu_rdata),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_ack(p_scr_ack), .scr_rdata(p_scr_rdata),
    .mem_ren(p_mem_ren), .mem_wen(p_mem_wen), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_rdata(p_mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic inr(input logic [31:0] a);
    return a < MB;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return inr(a) ? ref_mem[a[9:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = 32'($urandom_range(0, 255)) << 2;
    return ($urandom_range(0, 3) == 0) ? (w + MB) : w;
  endfunction

  initial begin
    logic        last_is_cpu, do_cpu, do_scr, cpu_first, cw;
    logic [31:0] ca, cd, sa, cpu_exp, scr_exp;
    int          c_cyc, s_cyc, n;

    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    do_reset();
    chk("rst_mem_ren", {31'h0, mem_ren}, 32'h0);
    chk("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
    chk("rst_acks", {30'h0, cpu_ack, scr_ack}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", cpu_rdata | scr_rdata, 32'h0);

    // CPU write then read
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    tick();
    chk("wr_c1_mem_wen", {31'h0, mem_wen}, 32'h1);
    chk("wr_c1_mem_ren", {31'h0, mem_ren}, 32'h0);
    chk("wr_c1_addr", mem_addr, 32'h10);
    chk("wr_c1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_c1_stall", {31'h0, cpu_stall}, 32'h1);
    tick();
    chk("wr_c2_ack", {31'h0, cpu_ack}, 32'h1);
    chk("wr_c2_stall", {31'h0, cpu_stall}, 32'h0);
    chk("wr_c2_mem_wen", {31'h0, mem_wen}, 32'h0);
    ref_mem[4] = 32'hDEADBEEF;
    cpu_req = 1'b0;
    tick();
    chk("wr_c3_ack", {31'h0, cpu_ack}, 32'h0);
    cpu_req = 1'b1; cpu_wen = 1'b0;
    tick();
    chk("rd_c1_mem_ren", {31'h0, mem_ren}, 32'h1);
    chk("rd_c1_ack", {31'h0, cpu_ack}, 32'h0);
    tick();
    chk("rd_c2_ack", {31'h0, cpu_ack}, 32'h1);
    chk("rd_c2_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rd_c2_scr_rdata", scr_rdata, 32'h0);
    cpu_req = 1'b0;
    tick();

    // Out-of-range reads
    foreach (ca[i]) begin end
    for (int k = 0; k < 2; k++) begin
      cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = (k == 0) ? 32'h800 : 32'(MB);
      tick();
      chk("oor_c1_mem_ren", {31'h0, mem_ren}, 32'h0);
      tick();
      chk("oor_c2_ack", {31'h0, cpu_ack}, 32'h1);
      chk("oor_c2_rdata", cpu_rdata, 32'h0);
      cpu_req = 1'b0;
      tick();
    end
    cpu_req = 1'b1; cpu_addr = 32'(MB - 4);
    tick();
    chk("edge_in_range_ren", {31'h0, mem_ren}, 32'h1);
    tick();
    cpu_req = 1'b0;
    tick();

    // One-cycle screen request still completes
    scr_addr = 32'h10; scr_req = 1'b1;
    tick();
    chk("scr_c1_mem_ren", {31'h0, mem_ren}, 32'h1);
    scr_req = 1'b0;
    tick();
    chk("scr_c2_ack", {31'h0, scr_ack}, 32'h1);
    chk("scr_c2_rdata", scr_rdata, 32'hDEADBEEF);
    chk("scr_c2_cpu_rdata", cpu_rdata, 32'h0);
    tick();
    chk("scr_c3_ack", {31'h0, scr_ack}, 32'h0);

    // Reset during ACCESS drops the access
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h12345678;
    tick();
    chk("rsta_c1_mem_wen", {31'h0, mem_wen}, 32'h1);
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    ref_mem[16] = 32'h12345678;  // strobe was high at this edge
    chk("rsta_c2_mem_wen", {31'h0, mem_wen}, 32'h0);
    chk("rsta_c2_ack", {31'h0, cpu_ack}, 32'h0);
    reset = 1'b0;
    tick();
    chk("rsta_c3_ack", {31'h0, cpu_ack}, 32'h0);
    chk("rsta_c3_strobes", {30'h0, mem_ren, mem_wen}, 32'h0);
    cpu_req = 1'b1; cpu_wen = 1'b0;
    tick();
    chk("rsta_rd_c1_ren", {31'h0, mem_ren}, 32'h1);
    tick();
    chk("rsta_rd_c2_ack", {31'h0, cpu_ack}, 32'h1);
    chk("rsta_rd_c2_rdata", cpu_rdata, 32'h12345678);
    cpu_req = 1'b0;
    tick();

    // Contention held from reset: round-robin vs CPU priority
    do_reset();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h10;
    scr_req = 1'b1; scr_addr = 32'h40;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("rr_cpu_ack_c%0d", c), {31'h0, cpu_ack}, {31'h0, (c == 2 || c == 8)});
      chk($sformatf("rr_scr_ack_c%0d", c), {31'h0, scr_ack}, {31'h0, (c == 5 || c == 11)});
      chk($sformatf("pr_cpu_ack_c%0d", c), {31'h0, p_cpu_ack}, {31'h0, (c % 3 == 2)});
      chk($sformatf("pr_scr_ack_c%0d", c), {31'h0, p_scr_ack}, 32'h0);
    end
    cpu_req = 1'b0;
    for (int c = 13; c <= 14; c++) begin
      tick();
      chk($sformatf("rr_scr_ack_c%0d", c), {31'h0, scr_ack}, {31'h0, (c == 14)});
      chk($sformatf("pr_scr_ack_c%0d", c), {31'h0, p_scr_ack}, {31'h0, (c == 14)});
    end
    scr_req = 1'b0;
    tick();

    // Randomized rounds against the transaction model
    do_reset();
    last_is_cpu = 1'b0;
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 3);
      do_cpu = (n != 2);
      do_scr = (n != 1);
      cw = 1'($urandom_range(0, 1));
      ca = rand_addr(); cd = $urandom; sa = rand_addr();
      cpu_first = do_cpu && (!do_scr || !last_is_cpu);
      c_cyc = cpu_first ? 2 : 5;
      s_cyc = (do_scr && !cpu_first) ? 2 : 5;
      cpu_exp = '0; scr_exp = '0;
      if (cpu_first) begin
        cpu_exp = rd(ca);
        if (do_cpu && cw && inr(ca)) ref_mem[ca[9:2]] = cd;
        scr_exp = rd(sa);
      end else begin
        scr_exp = rd(sa);
        cpu_exp = rd(ca);
        if (do_cpu && cw && inr(ca)) ref_mem[ca[9:2]] = cd;
      end
      cpu_req = do_cpu; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
      scr_req = do_scr; scr_addr = sa;
      n = (do_cpu && do_scr) ? 6 : 3;
      for (int c = 1; c <= n; c++) begin
        tick();
        chk($sformatf("rnd%0d_cpu_ack_c%0d", r, c), {31'h0, cpu_ack}, {31'h0, do_cpu && c == c_cyc});
        chk($sformatf("rnd%0d_scr_ack_c%0d", r, c), {31'h0, scr_ack}, {31'h0, do_scr && c == s_cyc});
        if (do_cpu && c == c_cyc - 1) begin
          chk($sformatf("rnd%0d_cpu_wen", r), {31'h0, mem_wen}, {31'h0, cw && inr(ca)});
          chk($sformatf("rnd%0d_cpu_ren", r), {31'h0, mem_ren}, {31'h0, !cw && inr(ca)});
        end
        if (do_scr && c == s_cyc - 1) begin
          chk($sformatf("rnd%0d_scr_ren", r), {31'h0, mem_ren}, {31'h0, inr(sa)});
          chk($sformatf("rnd%0d_scr_wen", r), {31'h0, mem_wen}, 32'h0);
        end
        if (do_cpu && c == c_cyc) begin
          if (!cw) chk($sformatf("rnd%0d_cpu_rdata", r), cpu_rdata, cpu_exp);
          cpu_req = 1'b0;
        end
        if (do_scr && c == s_cyc) begin
          chk($sformatf("rnd%0d_scr_rdata", r), scr_rdata, scr_exp);
          scr_req = 1'b0;
        end
      end
      last_is_cpu = (do_cpu && do_scr) ? !cpu_first : do_cpu;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, size of the data-memory window; addresses at or above it are out of range.
REQ-002 SHALL have parameter CPU_PRIO, default 0; 0 = round-robin, 1 = CPU always wins on contention.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cpu_req  input  1  CPU data-port request, held until cpu_ack.
REQ-006 SHALL have port cpu_wen  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cpu_addr  input  32  CPU byte address.
REQ-008 SHALL have port cpu_wdata  input  32  CPU write data.
REQ-009 SHALL have port cpu_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port cpu_stall  output  1  equals cpu_req AND NOT cpu_ack.
REQ-011 SHALL have port cpu_rdata  output  32  read data, valid while cpu_ack is high.
REQ-012 SHALL have port scr_req  input  1  screen-refresh read request, held until scr_ack.
REQ-013 SHALL have port scr_addr  input  32  screen byte address.
REQ-014 SHALL have port scr_ack  output  1  one-cycle completion pulse.
REQ-015 SHALL have port scr_rdata  output  32  read data, valid while scr_ack is high.
REQ-016 SHALL have port mem_ren  output  1  registered memory read strobe.
REQ-017 SHALL have port mem_wen  output  1  registered memory write strobe.
REQ-018 SHALL have port mem_addr  output  32  registered memory address.
REQ-019 SHALL have port mem_wdata  output  32  registered memory write data.
REQ-020 SHALL have port mem_rdata  input  32  memory read data, valid one cycle after mem_ren.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS and RESP, with register owner (CPU or SCR) and register last_owner.
REQ-022 IDLE, no request pending: SHALL remain in IDLE with mem_ren, mem_wen, cpu_ack and scr_ack all 0.
REQ-023 IDLE, a request pending at edge T: SHALL select owner, capture addr, wen (0 for SCR) and wdata, and go to ACCESS in cycle T+1.
REQ-024 Contention, CPU_PRIO=0: SHALL grant the requester that is not last_owner; last_owner resets to SCR, so the CPU wins the first contention.
REQ-025 Contention, CPU_PRIO=1: SHALL always grant the CPU.
REQ-026 ACCESS: SHALL drive mem_ren = NOT wen and mem_wen = wen with the captured addr and wdata for exactly one cycle, then go to RESP.
REQ-027 RESP: SHALL pulse the owner's ack for one cycle, route mem_rdata to the owner's rdata, update last_owner to owner, and return to IDLE.
REQ-028 Latency: request sampled at edge T gives ack in cycle T+2; peak throughput is one access per 3 cycles.
REQ-029 Out of range (captured addr >= MEM_BYTES): SHALL keep mem_ren and mem_wen at 0 in ACCESS, still ack in RESP, and return rdata 0.
REQ-030 mem_addr SHALL equal the captured byte address unmodified; alignment is the requester's responsibility.
REQ-031 Non-owner rdata SHALL be 0; cpu_ack and scr_ack SHALL never be high in the same cycle.
REQ-032 Requests SHALL be sampled only in IDLE; a request raised during ACCESS or RESP waits.
REQ-033 A request dropped before its ack SHALL still complete and ack; no abort mechanism exists.
REQ-034 A request held high across its own ack SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-035 reset high at a clock edge SHALL force state IDLE and last_owner SCR, with mem_ren, mem_wen, cpu_ack and scr_ack 0 and mem_addr, mem_wdata, cpu_rdata and scr_rdata 0.
REQ-036 Reset during ACCESS or RESP SHALL drop the in-flight access: no ack is issued, and any strobe deasserts from the next cycle.

Verification
REQ-037 CPU write then read: cpu_wen=1, addr 0x10, wdata 0xDEADBEEF -> mem_wen high in cycle 1, cpu_ack in cycle 2; then a read of 0x10 -> cpu_rdata 0xDEADBEEF with cpu_ack 2 cycles after sampling.
REQ-038 Contention, CPU_PRIO=0: both requests held from reset -> order CPU, SCR, CPU, SCR; acks at cycles 2, 5, 8, 11; never two consecutive acks to the same requester.
REQ-039 Contention, CPU_PRIO=1: both requests held -> only cpu_ack pulses; scr_ack stays 0 until cpu_req drops.
REQ-040 Out of range: cpu read at 0x800 -> mem_ren stays 0, cpu_ack pulses at T+2, cpu_rdata 0; same for addr 1024 (first out-of-range byte).
REQ-041 Reset in ACCESS: reset asserted in cycle 1 of a CPU write -> mem_wen 0 from cycle 2, no cpu_ack, FSM in IDLE; a subsequent request completes normally.
REQ-042 Early drop: scr_req pulsed for one cycle -> scr_ack still pulses 2 cycles later with the memory word at scr_addr.
